// File: rtl/acc_i2c_arb.sv
// -----------------------------------------------------------------------------
// acc_i2c_arb
//
// Arbiter for the single accelerometer I2C bus shared by NUM_REQ requesters
// (index 0 = IRQ-driven sample reader, index 1 = APB register-access engine).
// Runs in the aclk domain between the requester engines and the I2C pads.
//
//   - Fixed priority (lower index wins) with an anti-starvation override:
//     a requester that has lost MAX_DEFER or more contested grants is
//     chosen ahead of plain priority.
//   - A bus-free guard interval of GUARD_CYCLES clocks follows every owner.
//   - A grant held for TIMEOUT_CYCLES clocks is revoked; the offender is
//     locked out until it drops its request for at least one cycle.
//   - The owner's SCL/SDA drive is muxed onto the pads; with no owner the
//     pads idle high.
//
// Ports
//   clk           in   arbiter clock (aclk)
//   rstb          in   asynchronous active-low reset
//   req           in   [NUM_REQ] level requests, held for the whole ownership
//   grant         out  [NUM_REQ] registered one-hot grant
//   req_scl       in   [NUM_REQ] per-requester SCL drive
//   req_sda_o     in   [NUM_REQ] per-requester SDA drive
//   req_sda_i     out  [NUM_REQ] per-requester SDA sense (1 for non-owners)
//   i2c_scl       out  SCL to pad
//   i2c_sda_o     out  SDA drive to pad
//   i2c_sda_i     in   SDA from pad
//   owner         out  [3] index of current grantee, valid while busy=1
//   busy          out  1 in GRANT or GUARD
//   timeout_flag  out  sticky, set on a forced revoke
//   timeout_clr   in   synchronous clear of timeout_flag (a set wins)
//   timeout_src   out  [3] index of the requester revoked last
//   o_dbg_state   out  [2] FSM state (0 IDLE, 1 GRANT, 2 GUARD)
//
// Handshake: req is a level. A requester raises req and keeps it high; the
// arbiter answers with grant one edge after it evaluates req in IDLE. The
// requester owns the bus for every cycle grant is high. Dropping req ends the
// ownership: grant falls on the next edge and the guard interval starts.
// -----------------------------------------------------------------------------
module acc_i2c_arb #(
    parameter int NUM_REQ        = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_DEFER      = 3
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    input  logic [NUM_REQ-1:0] req_scl,
    input  logic [NUM_REQ-1:0] req_sda_o,
    output logic [NUM_REQ-1:0] req_sda_i,
    output logic               i2c_scl,
    output logic               i2c_sda_o,
    input  logic               i2c_sda_i,
    output logic [2:0]         owner,
    output logic               busy,
    output logic               timeout_flag,
    input  logic               timeout_clr,
    output logic [2:0]         timeout_src,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [NUM_REQ-1:0]       r_grant;
    logic [2:0]               r_owner;
    logic                     r_busy;
    logic                     r_tflag;
    logic [2:0]               r_tsrc;
    logic [NUM_REQ-1:0]       r_lock;
    logic [NUM_REQ-1:0][3:0]  r_defer;
    logic [15:0]              r_hold_cnt;
    logic [7:0]               r_guard_cnt;

    // ------------------------------------------------------------------
    // Winner selection and grant-phase decode
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_any_elig;
    logic               w_forced_hit;
    logic               w_low_hit;
    logic [2:0]         w_forced_idx;
    logic [2:0]         w_low_idx;
    logic [2:0]         w_win_idx;
    logic               w_owner_req;
    logic               w_timeout_hit;
    logic               w_guard_done;
    logic               w_any_grant;

    always_comb begin
        w_elig       = req & ~r_lock;
        w_any_elig   = |w_elig;
        w_forced_hit = 1'b0;
        w_forced_idx = 3'd0;
        w_low_hit    = 1'b0;
        w_low_idx    = 3'd0;
        // Ascending scan: the first hit in each category is the lowest index.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_elig[j] && !w_low_hit) begin
                w_low_hit = 1'b1;
                w_low_idx = 3'(j);
            end
            if (w_elig[j] && (r_defer[j] >= 4'(MAX_DEFER)) && !w_forced_hit) begin
                w_forced_hit = 1'b1;
                w_forced_idx = 3'(j);
            end
        end
        // A starved requester overrides plain priority.
        w_win_idx = w_forced_hit ? w_forced_idx : w_low_idx;
        w_win_oh  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_win_oh[j] = (3'(j) == w_win_idx);
        end
        // grant is one-hot, so masking req with it reads the owner's request.
        w_owner_req   = |(r_grant & req);
        w_timeout_hit = (r_hold_cnt == 16'(TIMEOUT_CYCLES - 1));
        w_guard_done  = (r_guard_cnt == 8'(GUARD_CYCLES - 1));
    end

    // ------------------------------------------------------------------
    // Arbitration FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= 3'd0;
            r_busy      <= 1'b0;
            r_tflag     <= 1'b0;
            r_tsrc      <= 3'd0;
            r_lock      <= '0;
            r_defer     <= '0;
            r_hold_cnt  <= 16'd0;
            r_guard_cnt <= 8'd0;
        end else begin
            // Any cycle with req low lifts that requester's lockout.
            r_lock <= r_lock & req;

            // The clear sits ahead of the FSM so a same-cycle set wins.
            if (timeout_clr) begin
                r_tflag <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        r_state    <= ST_GRANT;
                        r_grant    <= w_win_oh;
                        r_owner    <= w_win_idx;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= 16'd0;
                        // Every eligible loser records one more lost contest.
                        for (int j = 0; j < NUM_REQ; j++) begin
                            if (w_win_oh[j]) begin
                                r_defer[j] <= 4'd0;
                            end else if (w_elig[j] && (r_defer[j] != 4'hF)) begin
                                r_defer[j] <= r_defer[j] + 4'd1;
                            end
                        end
                    end
                end

                ST_GRANT: begin
                    // Release is tested first: a drop on the last allowed
                    // cycle is an orderly release, not a timeout.
                    if (!w_owner_req) begin
                        r_state     <= ST_GUARD;
                        r_grant     <= '0;
                        r_guard_cnt <= 8'd0;
                    end else if (w_timeout_hit) begin
                        r_state     <= ST_GUARD;
                        r_grant     <= '0;
                        r_guard_cnt <= 8'd0;
                        r_tflag     <= 1'b1;
                        r_tsrc      <= r_owner;
                        // Owner's req is high here, so the lock sticks.
                        r_lock      <= (r_lock & req) | r_grant;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end

                ST_GUARD: begin
                    // Requests raised here simply wait; IDLE evaluates them.
                    if (w_guard_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pad mux, combinational from the registered grant so an asynchronous
    // reset returns the pads to idle-high without waiting for a clock.
    // ------------------------------------------------------------------
    assign w_any_grant = |r_grant;
    assign i2c_scl     = w_any_grant ? |(r_grant & req_scl)   : 1'b1;
    assign i2c_sda_o   = w_any_grant ? |(r_grant & req_sda_o) : 1'b1;
    // Only the owner senses the pad; everyone else sees a released line.
    assign req_sda_i   = ~r_grant | {NUM_REQ{i2c_sda_i}};

    assign grant        = r_grant;
    assign owner        = r_owner;
    assign busy         = r_busy;
    assign timeout_flag = r_tflag;
    assign timeout_src  = r_tsrc;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_acc_i2c_arb.sv
module tb_acc_i2c_arb;

  localparam int NREQ = 2;

  // clock / reset
  logic clk;
  logic rstb;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] req_scl;
  logic [NREQ-1:0] req_sda_o;
  logic [NREQ-1:0] req_sda_i;
  logic            i2c_scl;
  logic            i2c_sda_o;
  logic            i2c_sda_i;
  logic [2:0]      owner;
  logic            busy;
  logic            timeout_flag;
  logic            timeout_clr;
  logic [2:0]      timeout_src;
  logic [1:0]      dbg_state;

  acc_i2c_arb #(
    .NUM_REQ        (NREQ),
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .MAX_DEFER      (3)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .req          (req),
    .grant        (grant),
    .req_scl      (req_scl),
    .req_sda_o    (req_sda_o),
    .req_sda_i    (req_sda_i),
    .i2c_scl      (i2c_scl),
    .i2c_sda_o    (i2c_sda_o),
    .i2c_sda_i    (i2c_sda_i),
    .owner        (owner),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr),
    .timeout_src  (timeout_src),
    .o_dbg_state  (dbg_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: advance one clock and land 1 ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] exp);
    int n;
    n = 0;
    while (grant == '0 && n < 30) begin
      step();
      n++;
    end
    check(name, grant, exp);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  // one contest with both requesters high; the winner releases for a cycle
  task automatic contest(input string name, input logic [NREQ-1:0] exp);
    req = 2'b11;
    wait_grant({name, " grant"}, exp);
    req = 2'b11 & ~grant;
    step();
    check({name, " release"}, grant, 2'b00);
    req = 2'b11;
  endtask

  // vector table: inputs applied, one clock, then outputs compared
  typedef struct {
    logic [1:0] req;
    logic [1:0] scl;
    logic [1:0] sdao;
    logic       sdai;
    logic [1:0] e_grant;
    logic       e_busy;
    logic [2:0] e_owner;
    logic       e_scl;
    logic       e_sdao;
    logic [1:0] e_sdai;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;

    // single request, release, guard, then a contested grant that drops
    // in the same cycle it arrives, then a plain grant to requester 1
    tbl[0]  = '{2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 1'b1, 3'd1, 1'b0, 1'b1, 2'b01};
    tbl[1]  = '{2'b10, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 3'd1, 1'b1, 1'b0, 2'b11};
    tbl[2]  = '{2'b10, 2'b01, 2'b11, 1'b0, 2'b10, 1'b1, 3'd1, 1'b0, 1'b1, 2'b01};
    tbl[3]  = '{2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b11};
    tbl[4]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b11};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b11};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b11};
    tbl[7]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'd1, 1'b1, 1'b1, 2'b11};
    tbl[8]  = '{2'b11, 2'b10, 2'b10, 1'b0, 2'b01, 1'b1, 3'd0, 1'b0, 1'b0, 2'b10};
    tbl[9]  = '{2'b10, 2'b01, 2'b01, 1'b1, 2'b00, 1'b1, 3'd0, 1'b1, 1'b1, 2'b11};
    tbl[10] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 1'b1, 2'b11};
    tbl[11] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 1'b1, 2'b11};
    tbl[12] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd0, 1'b1, 1'b1, 2'b11};
    tbl[13] = '{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 2'b11};
    tbl[14] = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 3'd1, 1'b1, 1'b0, 2'b01};
    tbl[15] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b11};

    // reset block
    rstb        = 1'b0;
    req         = '0;
    req_scl     = '0;
    req_sda_o   = '0;
    i2c_sda_i   = 1'b0;
    timeout_clr = 1'b0;
    #12;
    check("rst grant", grant, 2'b00);
    check("rst busy", busy, 1'b0);
    check("rst owner", owner, 3'd0);
    check("rst tflag", timeout_flag, 1'b0);
    check("rst tsrc", timeout_src, 3'd0);
    check("rst scl", i2c_scl, 1'b1);
    check("rst sdao", i2c_sda_o, 1'b1);
    check("rst sdai", req_sda_i, 2'b11);
    check("rst state", dbg_state, 2'd0);
    rstb = 1'b1;
    step();

    // table-driven vectors
    for (int i = 0; i < 16; i++) begin
      req       = tbl[i].req;
      req_scl   = tbl[i].scl;
      req_sda_o = tbl[i].sdao;
      i2c_sda_i = tbl[i].sdai;
      step();
      check($sformatf("row%0d grant", i), grant, tbl[i].e_grant);
      check($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_busy) check($sformatf("row%0d owner", i), owner, tbl[i].e_owner);
      check($sformatf("row%0d scl", i), i2c_scl, tbl[i].e_scl);
      check($sformatf("row%0d sdao", i), i2c_sda_o, tbl[i].e_sdao);
      check($sformatf("row%0d sdai", i), req_sda_i, tbl[i].e_sdai);
    end
    req = '0;
    wait_idle("tbl idle");

    // anti-starvation: three contests to 0, the fourth forced to 1, then 0 again
    contest("c1", 2'b01);
    contest("c2", 2'b01);
    contest("c3", 2'b01);
    contest("c4", 2'b10);
    contest("c5", 2'b01);
    req = '0;
    wait_idle("contest idle");

    // timeout: requester 0 holds past the limit
    req = 2'b01;
    wait_grant("to grant", 2'b01);
    n = 0;
    while (grant == 2'b01 && n < 40) begin
      n++;
      step();
    end
    check("to hold cycles", n, 16);
    check("to grant drop", grant, 2'b00);
    check("to flag", timeout_flag, 1'b1);
    check("to src", timeout_src, 3'd0);
    check("to busy", busy, 1'b1);
    req = 2'b11;
    wait_grant("to other grant", 2'b10);
    check("to other owner", owner, 3'd1);
    step();
    step();
    req = 2'b01;
    step();
    wait_idle("to other idle");
    repeat (6) step();
    check("to locked grant", grant, 2'b00);
    check("to locked state", dbg_state, 2'd0);
    req = 2'b00;
    step();
    req = 2'b01;
    step();
    check("to unlock grant", grant, 2'b01);
    req = 2'b00;
    step();
    wait_idle("to unlock idle");

    // plain flag clear
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    check("clr flag", timeout_flag, 1'b0);
    check("clr src kept", timeout_src, 3'd0);

    // release on the last allowed cycle is not a timeout
    req = 2'b01;
    wait_grant("coll grant", 2'b01);
    repeat (15) step();
    check("coll held", grant, 2'b01);
    req = 2'b00;
    step();
    check("coll grant drop", grant, 2'b00);
    check("coll flag", timeout_flag, 1'b0);
    check("coll busy", busy, 1'b1);
    wait_idle("coll idle");
    req = 2'b01;
    step();
    check("coll regrant", grant, 2'b01);
    req = 2'b00;
    step();
    wait_idle("coll regrant idle");

    // timeout of requester 1 coinciding with a clear: set wins
    req = 2'b10;
    wait_grant("set-clr grant", 2'b10);
    repeat (15) step();
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    check("set-clr flag", timeout_flag, 1'b1);
    check("set-clr src", timeout_src, 3'd1);
    check("set-clr grant", grant, 2'b00);

    // asynchronous reset in the middle of a grant
    req = 2'b01;
    wait_grant("ar grant", 2'b01);
    req_scl   = 2'b00;
    req_sda_o = 2'b00;
    #1;
    check("ar scl low", i2c_scl, 1'b0);
    #2;
    rstb = 1'b0;
    #1;
    check("ar grant", grant, 2'b00);
    check("ar scl", i2c_scl, 1'b1);
    check("ar sdao", i2c_sda_o, 1'b1);
    check("ar busy", busy, 1'b0);
    check("ar flag", timeout_flag, 1'b0);
    check("ar src", timeout_src, 3'd0);
    #1;
    rstb = 1'b1;
    step();
    check("ar regrant", grant, 2'b01);
    check("ar regrant busy", busy, 1'b1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_i2c_arb.md
Name: acc_i2c_arb

Overview:
Arbiter for the single accelerometer I2C bus, which is shared by NUM_REQ requesters. Index 0 is the IRQ-driven sample reader; index 1 is the APB register-access engine.
- Grants the bus to one requester at a time under fixed priority, with an anti-starvation override.
- Inserts a bus-free guard interval between owners.
- Forcibly revokes a grant held too long.
- Muxes the owner's SCL/SDA onto the pins.
Sits in the aclk (1 MHz) domain between the requester engines and the I2C pads.

Parameters:
NUM_REQ, 2, number of requesters (2..8); lower index = higher priority
GUARD_CYCLES, 4, idle clocks between release and next grant (1..255)
TIMEOUT_CYCLES, 4096, max clocks a grant may be held (16..65535)
MAX_DEFER, 3, grants a waiting requester may lose before it is forced next (1..15)

Ports:
clk  in  1  arbiter clock (aclk)
rstb  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  level request; held high for the whole ownership
grant  out  NUM_REQ  one-hot grant, registered
req_scl  in  NUM_REQ  per-requester SCL drive
req_sda_o  in  NUM_REQ  per-requester SDA drive
req_sda_i  out  NUM_REQ  per-requester SDA sense
i2c_scl  out  1  SCL to pad
i2c_sda_o  out  1  SDA drive to pad
i2c_sda_i  in  1  SDA from pad
owner  out  3  index of current grantee, valid when busy=1
busy  out  1  1 in GRANT or GUARD
timeout_flag  out  1  sticky; set on forced revoke
timeout_clr  in  1  synchronous clear of timeout_flag
timeout_src  out  3  index of the requester revoked last

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous, active-low (rstb).
- Reset values:
  - grant=0, owner=0, busy=0, timeout_flag=0, timeout_src=0.
  - All defer counters 0, all lockouts 0, state IDLE.
- States: IDLE, GRANT, GUARD.
- IDLE:
  - If any eligible req, pick winner k and assert grant[k] on the next edge (1-cycle latency). Go to GRANT, owner=k, busy=1.
  - Eligible means req[j]=1 and lock[j]=0.
  - Winner selection: lowest-index eligible j with defer[j]>=MAX_DEFER; if none, lowest-index eligible j.
  - On a grant to k: defer[k]<=0. For every other eligible j, defer[j]<=defer[j]+1, saturating at 15.
- GRANT:
  - hold_cnt increments each cycle from 0.
  - If req[owner]=0: grant<=0 next edge, go to GUARD.
  - Else if hold_cnt==TIMEOUT_CYCLES-1: grant<=0, timeout_flag<=1, timeout_src<=owner, lock[owner]<=1, go to GUARD.
  - Release has priority over timeout in the same cycle; that case is not a timeout.
- GUARD:
  - Counts GUARD_CYCLES clocks with busy=1, grant=0, then goes to IDLE.
  - Requests arriving during GUARD are held and evaluated in IDLE.
- Lockout: lock[j] clears in any cycle where req[j]=0. A timed-out requester must drop req at least one cycle before it can be granted again.
- timeout_clr clears timeout_flag. If a set and a clear coincide, the set wins.
- Pin muxing (combinational from registered grant):
  - grant[k]=1: i2c_scl=req_scl[k], i2c_sda_o=req_sda_o[k], req_sda_i[k]=i2c_sda_i.
  - No grant: i2c_scl=1, i2c_sda_o=1 (bus idle).
  - req_sda_i of every non-owner = 1.
- A requester that drops req in the same cycle the grant arrives still owns for that cycle, then releases normally through GUARD.
- Reset mid-GRANT: pins return to idle-high immediately (asynchronous). Counters and lockouts clear.
- grant is never multi-hot. At most one requester sees grant in any cycle.

Test Plan:
- Single request: req=2'b10 in IDLE -> grant=2'b10 one cycle later, busy=1; the bench drives req_scl[1] pattern and sees it on i2c_scl. Drop req -> grant=0 next edge, busy stays 1 for 4 cycles, then 0.
- Simultaneous request: req=2'b11 from IDLE -> grant=2'b01 and defer[1]=1. After 3 such contested grants to 0, the 4th contest grants 1 even with req[0]=1.
- Timeout (TIMEOUT_CYCLES=16 in this test): req[0] held continuously -> grant[0] drops after exactly 16 grant cycles, timeout_flag=1, timeout_src=0. With req[0] still high, req[1] is granted after the guard. req[0] gets no grant until it toggles low.
- Release/timeout collision: req[0] drops on hold_cnt==TIMEOUT_CYCLES-1 -> timeout_flag stays 0 and no lockout is set.
- Flag clear: timeout_clr pulse -> flag=0 next edge. A new timeout coinciding with the clear -> flag=1.
- Async reset mid-GRANT: rstb low -> grant=0, i2c_scl=1, i2c_sda_o=1 without a clock edge. After rstb goes high, a pending req is granted 1 cycle later.
